// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB arbiter: round-robin grant with INCR4 burst locking,
// address/data-phase muxing onto a single slave port.
module ahb_arbiter_2m #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hrst,
    // master 0 (I-cache refill)
    input  logic              m0_hbusreq,
    output logic              m0_hgrant,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [DATA_W-1:0] m0_hwdata,
    // master 1 (test/debug)
    input  logic              m1_hbusreq,
    output logic              m1_hgrant,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [DATA_W-1:0] m1_hwdata,
    // slave side
    output logic              hselx,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready_out,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    // shared master-side response
    output logic              hready,
    output logic [DATA_W-1:0] hrdata_m,
    output logic              hresp_m
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR4  = 3'b011;

    state_t      r_state, w_state_nxt;
    logic        r_last;            // 1 = m1 served last
    logic        r_dp_own, r_dp_valid, r_lock, w_lock_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;

    assign m0_hgrant = (r_state == OWN0);
    assign m1_hgrant = (r_state == OWN1);

    always_comb begin
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = '0;
        hburst = '0;
        case (r_state)
            OWN0: begin
                haddr = m0_haddr; htrans = m0_htrans; hwrite = m0_hwrite;
                hsize = m0_hsize; hburst = m0_hburst;
            end
            OWN1: begin
                haddr = m1_haddr; htrans = m1_htrans; hwrite = m1_hwrite;
                hsize = m1_hsize; hburst = m1_hburst;
            end
            default: ;
        endcase
    end

    assign hselx  = (htrans == TR_NONSEQ) || (htrans == TR_SEQ);
    assign hwdata = !r_dp_valid ? '0 : (r_dp_own ? m1_hwdata : m0_hwdata);

    assign hready   = hready_out;
    assign hrdata_m = hrdata;
    assign hresp_m  = hresp;

    // Lock state as it will be after this edge; arbitration is gated by it so
    // the edge accepting an INCR4 NONSEQ cannot hand the bus away.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_lock_nxt = r_lock;
        if (hready_out) begin
            if (hresp) begin
                w_cnt_nxt  = 2'd0;
                w_lock_nxt = 1'b0;
            end else if (htrans == TR_NONSEQ) begin
                w_lock_nxt = (hburst == BU_INCR4);
                w_cnt_nxt  = (hburst == BU_INCR4) ? 2'd3 : 2'd0;
            end else if (htrans == TR_SEQ && r_lock) begin
                w_cnt_nxt  = r_cnt - 2'd1;
                w_lock_nxt = (r_cnt != 2'd1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (hready_out && !w_lock_nxt) begin
            case ({m1_hbusreq, m0_hbusreq})
                2'b01:   w_state_nxt = OWN0;
                2'b10:   w_state_nxt = OWN1;
                2'b11:   w_state_nxt = r_last ? OWN0 : OWN1;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_dp_own   <= 1'b0;
            r_dp_valid <= 1'b0;
            r_lock     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == OWN0)
                r_last <= 1'b0;
            else if (w_state_nxt == OWN1)
                r_last <= 1'b1;
            if (hready_out) begin
                r_dp_own   <= (r_state == OWN1);
                r_dp_valid <= hselx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Directed bench for ahb_arbiter_2m: reset, single transfer, tie, INCR4 lock,
// wait states, error abort and asynchronous reset mid-burst.
module tb_ahb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hrst;
    logic          m0_hbusreq, m0_hgrant, m0_hwrite;
    logic [AW-1:0] m0_haddr;
    logic [1:0]    m0_htrans;
    logic [2:0]    m0_hsize, m0_hburst;
    logic [DW-1:0] m0_hwdata;
    logic          m1_hbusreq, m1_hgrant, m1_hwrite;
    logic [AW-1:0] m1_haddr;
    logic [1:0]    m1_htrans;
    logic [2:0]    m1_hsize, m1_hburst;
    logic [DW-1:0] m1_hwdata;
    logic          hselx, hwrite, hready_out, hresp, hready, hresp_m;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [DW-1:0] hwdata, hrdata, hrdata_m;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .hclk(hclk), .hrst(hrst),
        .m0_hbusreq(m0_hbusreq), .m0_hgrant(m0_hgrant), .m0_haddr(m0_haddr),
        .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
        .m1_hbusreq(m1_hbusreq), .m1_hgrant(m1_hgrant), .m1_haddr(m1_haddr),
        .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
        .hselx(hselx), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready_out(hready_out), .hrdata(hrdata), .hresp(hresp),
        .hready(hready), .hrdata_m(hrdata_m), .hresp_m(hresp_m)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_hbusreq = 0; m0_haddr = '0; m0_htrans = 2'b00; m0_hwrite = 0;
        m0_hsize = 3'b010; m0_hburst = 3'b000; m0_hwdata = '0;
        m1_hbusreq = 0; m1_haddr = '0; m1_htrans = 2'b00; m1_hwrite = 0;
        m1_hsize = 3'b010; m1_hburst = 3'b000; m1_hwdata = '0;
        hready_out = 1; hresp = 0; hrdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        hrst = 1;
        step();
        step();
        hrst = 0;
    endtask

    task automatic m0_drive(input logic [1:0] tr, input logic [AW-1:0] a, input logic [2:0] bu);
        m0_htrans = tr; m0_haddr = a; m0_hburst = bu; m0_hwrite = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_hbusreq = 1; m1_hbusreq = 1;
        hrst = 1;
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b00) begin bad++; $display("FAIL rst_grant got %b want 00", {m1_hgrant, m0_hgrant}); end
        total++; if (htrans !== 2'b00 || hselx !== 1'b0) begin bad++; $display("FAIL rst_trans got %b/%b want 00/0", htrans, hselx); end
        total++; if (haddr !== '0 || hwdata !== '0) begin bad++; $display("FAIL rst_addr_data got %h/%h want 0/0", haddr, hwdata); end
        step();
        total++; if (m0_hgrant !== 1'b0) begin bad++; $display("FAIL rst_held got %b want 0", m0_hgrant); end
        hrdata = 32'h1234_5678; hresp = 1; hready_out = 0;
        #1;
        total++; if (hrdata_m !== 32'h1234_5678 || hresp_m !== 1'b1 || hready !== 1'b0) begin bad++; $display("FAIL passthru got %h/%b/%b want 12345678/1/0", hrdata_m, hresp_m, hready); end
        hresp = 0; hready_out = 1;
        #1;
        total++; if (hresp_m !== 1'b0 || hready !== 1'b1) begin bad++; $display("FAIL passthru2 got %b/%b want 0/1", hresp_m, hready); end
    endtask

    task automatic test_single();
        apply_reset();
        m0_hbusreq = 1;
        #1;
        total++; if (m0_hgrant !== 1'b0) begin bad++; $display("FAIL single_pre got %b want 0", m0_hgrant); end
        step();
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b01) begin bad++; $display("FAIL single_grant got %b want 01", {m1_hgrant, m0_hgrant}); end
        m0_drive(2'b10, 32'h100, 3'b000);
        m0_hbusreq = 0;
        #1;
        total++; if (haddr !== 32'h100 || htrans !== 2'b10 || hselx !== 1'b1 || hwrite !== 1'b1) begin bad++; $display("FAIL single_addr got %h/%b/%b want 100/10/1", haddr, htrans, hselx); end
        total++; if (hwdata !== '0) begin bad++; $display("FAIL single_nodata got %h want 0", hwdata); end
        step();
        m0_drive(2'b00, 32'h0, 3'b000);
        m0_hwdata = 32'hCAFE_0001;
        #1;
        total++; if (hwdata !== 32'hCAFE_0001) begin bad++; $display("FAIL single_wdata got %h want cafe0001", hwdata); end
        total++; if (m0_hgrant !== 1'b0 || htrans !== 2'b00 || hselx !== 1'b0) begin bad++; $display("FAIL single_idle got %b/%b/%b want 0/00/0", m0_hgrant, htrans, hselx); end
        step();
        total++; if (hwdata !== '0) begin bad++; $display("FAIL single_wdata_clr got %h want 0", hwdata); end
    endtask

    task automatic test_tie();
        apply_reset();
        m0_hbusreq = 1; m1_hbusreq = 1;
        m0_hwdata = 32'hA0; m1_hwdata = 32'hB1;
        step();
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b01) begin bad++; $display("FAIL tie_first got %b want 01", {m1_hgrant, m0_hgrant}); end
        m0_drive(2'b10, 32'h300, 3'b000);
        #1;
        total++; if (haddr !== 32'h300 || hselx !== 1'b1) begin bad++; $display("FAIL tie_addr0 got %h/%b want 300/1", haddr, hselx); end
        step();
        m0_drive(2'b00, 32'h0, 3'b000);
        m1_htrans = 2'b10; m1_haddr = 32'h400;
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b10) begin bad++; $display("FAIL tie_rr got %b want 10", {m1_hgrant, m0_hgrant}); end
        total++; if (haddr !== 32'h400 || hwdata !== 32'hA0) begin bad++; $display("FAIL tie_mux1 got %h/%h want 400/a0", haddr, hwdata); end
        step();
        m1_htrans = 2'b00;
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b01 || hwdata !== 32'hB1) begin bad++; $display("FAIL tie_back got %b/%h want 01/b1", {m1_hgrant, m0_hgrant}, hwdata); end
    endtask

    task automatic test_incr4();
        apply_reset();
        m0_hbusreq = 1;
        step();
        m0_drive(2'b10, 32'h200, 3'b011);
        m1_hbusreq = 1;
        for (int unsigned i = 1; i < 4; i++) begin
            step();
            m0_drive(2'b11, 32'h200 + 4 * i, 3'b011);
            m0_hwdata = 32'hD000 + i;
            #1;
            total++; if ({m1_hgrant, m0_hgrant} !== 2'b01 || haddr !== 32'h200 + 4 * i) begin bad++; $display("FAIL incr4_beat%0d got %b/%h want 01/%h", i, {m1_hgrant, m0_hgrant}, haddr, 32'h200 + 4 * i); end
        end
        step();
        m0_drive(2'b00, 32'h0, 3'b000);
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b10) begin bad++; $display("FAIL incr4_release got %b want 10", {m1_hgrant, m0_hgrant}); end
        total++; if (hwdata !== 32'hD003) begin bad++; $display("FAIL incr4_lastdata got %h want d003", hwdata); end
    endtask

    task automatic test_wait();
        apply_reset();
        m0_hbusreq = 1;
        step();
        m0_drive(2'b10, 32'h500, 3'b011);
        m1_hbusreq = 1;
        step();
        m0_drive(2'b11, 32'h504, 3'b011);
        m0_hwdata = 32'h11;
        hready_out = 0;
        m0_hbusreq = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            total++; if ({m1_hgrant, m0_hgrant} !== 2'b01 || hwdata !== 32'h11 || haddr !== 32'h504) begin bad++; $display("FAIL wait_%0d got %b/%h/%h want 01/11/504", i, {m1_hgrant, m0_hgrant}, hwdata, haddr); end
        end
        hready_out = 1;
        m0_hbusreq = 1;
        step();
        m0_drive(2'b11, 32'h508, 3'b011);
        #1;
        total++; if (m0_hgrant !== 1'b1) begin bad++; $display("FAIL wait_beat3 got %b want 1", m0_hgrant); end
        step();
        m0_drive(2'b11, 32'h50C, 3'b011);
        #1;
        total++; if (m0_hgrant !== 1'b1) begin bad++; $display("FAIL wait_beat4 got %b want 1", m0_hgrant); end
        step();
        m0_drive(2'b00, 32'h0, 3'b000);
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b10) begin bad++; $display("FAIL wait_release got %b want 10", {m1_hgrant, m0_hgrant}); end
    endtask

    task automatic test_error();
        apply_reset();
        m0_hbusreq = 1;
        step();
        m0_drive(2'b10, 32'h600, 3'b011);
        m1_hbusreq = 1;
        step();
        m0_drive(2'b11, 32'h604, 3'b011);
        step();
        m0_drive(2'b11, 32'h608, 3'b011);
        hresp = 1;
        #1;
        total++; if (m0_hgrant !== 1'b1 || hresp_m !== 1'b1) begin bad++; $display("FAIL err_pre got %b/%b want 1/1", m0_hgrant, hresp_m); end
        step();
        hresp = 0;
        m0_drive(2'b00, 32'h0, 3'b000);
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b10) begin bad++; $display("FAIL err_handover got %b want 10", {m1_hgrant, m0_hgrant}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m0_hbusreq = 1;
        step();
        m0_drive(2'b10, 32'h700, 3'b011);
        m1_hbusreq = 1;
        step();
        m0_drive(2'b11, 32'h704, 3'b011);
        m0_hwdata = 32'h77;
        step();
        m0_drive(2'b11, 32'h708, 3'b011);
        #1;
        hrst = 1;
        #1;
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b00 || htrans !== 2'b00 || hselx !== 1'b0) begin bad++; $display("FAIL rstmid_out got %b/%b/%b want 00/00/0", {m1_hgrant, m0_hgrant}, htrans, hselx); end
        total++; if (hwdata !== '0) begin bad++; $display("FAIL rstmid_data got %h want 0", hwdata); end
        m0_drive(2'b00, 32'h0, 3'b000);
        #1;
        hrst = 0;
        step();
        total++; if ({m1_hgrant, m0_hgrant} !== 2'b01) begin bad++; $display("FAIL rstmid_tie got %b want 01", {m1_hgrant, m0_hgrant}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_incr4();
        test_wait();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_2m.md
AHB_ARBITER_2M -- requirements
Module: ahb_arbiter_2m

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port hclk  in  1  sole clock, rising edge.
REQ-004 SHALL have port hrst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m0_hbusreq in 1, m0_hgrant out 1, m0_haddr in ADDR_W, m0_htrans in 2, m0_hwrite in 1, m0_hsize in 3, m0_hburst in 3, m0_hwdata in DATA_W (m0 = I-cache refill master).
REQ-006 SHALL have an identical port set prefixed m1_ (m1 = test/debug master).
REQ-007 SHALL have slave-side outputs hselx 1, haddr ADDR_W, htrans 2, hwrite 1, hsize 3, hburst 3, hwdata DATA_W.
REQ-008 SHALL have slave-side inputs hready_out 1, hrdata DATA_W, hresp 1.
REQ-009 SHALL have master-side outputs hready 1, hrdata_m DATA_W, hresp_m 1, shared by both masters.

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1; the address-phase owner is m0 in OWN0, m1 in OWN1, none in IDLE.
REQ-011 SHALL drive mX_hgrant high combinationally iff the state is OWNX.
REQ-012 SHALL mux the owner's haddr/htrans/hwrite/hsize/hburst onto the slave bus; in IDLE it drives htrans=IDLE (2'b00), haddr=0, hwrite=0.
REQ-013 SHALL drive hselx=1 whenever the muxed htrans is NONSEQ or SEQ, else 0.
REQ-014 SHALL register a data-phase owner (dp_own, dp_valid) on every hclk edge with hready_out=1, capturing the address-phase owner and whether the transfer was active.
REQ-015 SHALL select hwdata from dp_own's mX_hwdata; hwdata=0 when dp_valid=0.
REQ-016 SHALL pass hready_out->hready, hrdata->hrdata_m, hresp->hresp_m unmodified.
REQ-017 SHALL re-arbitrate only on an edge with hready_out=1 and no locked burst in progress.
REQ-018 SHALL lock the grant for INCR4 (hburst=3'b011): a 2-bit beat counter loads 3 on an accepted NONSEQ and decrements on each accepted SEQ; the lock is released when the counter reaches 0 on an accepted beat.
REQ-019 SHALL treat all other hburst values as unlocked: arbitration may move after any accepted beat.
REQ-020 SHALL arbitrate round-robin: the requesting master is granted; on simultaneous requests the master not served last wins; last_served resets to m1, so m0 wins the first tie.
REQ-021 SHALL keep the current owner while it alone requests; return to IDLE when neither requests and no lock is held.
REQ-022 SHALL on hresp=1 (ERROR) with hready_out=1 clear the beat counter and lock immediately.
REQ-023 SHALL keep the grant unchanged while hready_out=0 (wait states), regardless of hbusreq changes.
REQ-024 SHALL have handover latency of 1 cycle: hgrant changes on the edge after an arbitration point, and the new owner's address phase begins that cycle.

Reset
REQ-025 SHALL on hrst=1 asynchronously force state=IDLE, both hgrant=0, htrans=IDLE, hselx=0, dp_valid=0, dp_own=m0, beat counter=0, lock=0, last_served=m1.
REQ-026 SHALL on reset assertion mid-burst abandon the burst with no completion beat; outputs take reset values within the same cycle.
REQ-027 SHALL begin arbitrating on the first hclk edge after hrst deasserts.

Verification
REQ-028 Single request: m0_hbusreq=1 with idle bus -> m0_hgrant=1 next edge; NONSEQ 0x100 appears on haddr; the m0_hwdata word appears on hwdata one accepted cycle later.
REQ-029 Tie: both request from IDLE -> m0 granted; m0 issues one SINGLE and keeps requesting -> m1 granted next arbitration point.
REQ-030 Locked INCR4: m0 issues INCR4 at 0x200 while m1 requests -> m0 holds the grant for 4 accepted beats (0x200..0x20C) -> m1 granted the edge after the 4th.
REQ-031 Wait states: hready_out=0 for 3 cycles mid-burst with m1 requesting -> grant, beat counter and hwdata stay stable.
REQ-032 Error: hresp=1, hready_out=1 on beat 2 of INCR4 -> lock drops, m1 granted next edge.
REQ-033 Reset mid-burst: hrst=1 pulsed asynchronously on beat 3 -> hgrant=00, htrans=IDLE immediately; after release the tie goes to m0.
